// File: rtl/ysyx_24080014_axi_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_24080014_axi_pkg
// Shared definitions for the memory-side responders of the ysyx_24080014 core.
//   RESP_OKAY / RESP_SLVERR : AXI4-Lite response codes
//   sram_state_e            : responder FSM states, also exported on a debug port
// ---------------------------------------------------------------------------
package ysyx_24080014_axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_WAIT = 3'd1,
    ST_RD_RESP = 3'd2,
    ST_WR_WAIT = 3'd3,
    ST_WR_RESP = 3'd4
  } sram_state_e;

endpackage

// File: rtl/ysyx_24080014_sram_resp_if.sv
// ---------------------------------------------------------------------------
// ysyx_24080014_sram_resp_if
// AXI4-Lite-style request/response bundle between a requester (IFU/LSU) and
// the SRAM responder.
//   AR : araddr, arvalid, arready
//   R  : rdata, rresp, rvalid, rready
//   AW : awaddr, awvalid, awready
//   W  : wdata, wstrb, wvalid, wready
//   B  : bresp, bvalid, bready
// Handshake: a transfer happens on the rising edge where valid and ready are
// both 1. A source holds valid and its payload unchanged until that edge; a
// sink may change ready at any time and only counts the edge where both are 1.
// ---------------------------------------------------------------------------
interface ysyx_24080014_sram_resp_if;

  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

  modport slave (
    input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

endinterface

// File: rtl/ysyx_24080014_delay_cnt.sv
// ---------------------------------------------------------------------------
// ysyx_24080014_delay_cnt
// Loadable 4-bit down-counter used to time response latency.
//   clk, rst  : clock, asynchronous active-low reset (count -> 0)
//   load      : load load_val on the next rising edge (wins over en)
//   load_val  : value to load
//   en        : decrement by one per cycle; stops at 0, never wraps
//   done      : count == 0
// ---------------------------------------------------------------------------
module ysyx_24080014_delay_cnt (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       en,
  output logic       done
);

  logic [3:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= 4'd0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != 4'd0)) begin
      cnt <= cnt - 4'd1;
    end
  end

  assign done = (cnt == 4'd0);

endmodule

// File: rtl/ysyx_24080014_sram_resp.sv
// ---------------------------------------------------------------------------
// ysyx_24080014_sram_resp
// Memory-side responder: serves one read or write at a time from an internal
// word array, answering after a fixed programmable latency.
//   clk       : clock, rising edge
//   rst       : asynchronous active-low reset
//   bus       : slave side of the AR/R/AW/W/B bundle
//   dbg_state : current FSM state
// Parameters: BASE (first mapped byte), DEPTH (words, power of 2),
//             RD_LAT / WR_LAT (1..15 cycles from accept to response valid).
// ---------------------------------------------------------------------------
module ysyx_24080014_sram_resp
  import ysyx_24080014_axi_pkg::*;
#(
  parameter logic [31:0] BASE   = 32'h8000_0000,
  parameter int          DEPTH  = 4096,
  parameter int          RD_LAT = 1,
  parameter int          WR_LAT = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  ysyx_24080014_sram_resp_if.slave     bus,
  output sram_state_e                  dbg_state
);

  localparam int          AW   = $clog2(DEPTH);
  localparam logic [31:0] SPAN = 32'(4 * DEPTH);

  // The accept edge itself is the first latency cycle, so the counter only
  // covers the remaining wait cycles after RD_WAIT/WR_WAIT is entered; a
  // latency of 1 skips the wait state altogether.
  localparam logic [3:0] RD_PRE = (RD_LAT > 1) ? 4'(RD_LAT - 2) : 4'd0;
  localparam logic [3:0] WR_PRE = (WR_LAT > 1) ? 4'(WR_LAT - 2) : 4'd0;

  if (RD_LAT < 1 || RD_LAT > 15) begin : g_bad_rd_lat
    $error("ysyx_24080014_sram_resp: RD_LAT must be within 1..15");
  end
  if (WR_LAT < 1 || WR_LAT > 15) begin : g_bad_wr_lat
    $error("ysyx_24080014_sram_resp: WR_LAT must be within 1..15");
  end

  logic [31:0] mem [DEPTH];

  sram_state_e state;
  logic        rvalid_q;
  logic        bvalid_q;
  logic [31:0] rdata_q;
  logic [1:0]  rresp_q;
  logic [1:0]  bresp_q;
  logic [AW-1:0] rd_idx_q;
  logic        rd_err_q;
  logic        wr_err_q;

  // Address decode: unsigned offset from BASE, so addresses below BASE wrap
  // to large offsets and fail the same single compare. addr[1:0] is dropped.
  logic [31:0]   ar_off;
  logic [31:0]   aw_off;
  logic          ar_in;
  logic          aw_in;
  logic [AW-1:0] ar_idx;
  logic [AW-1:0] aw_idx;

  assign ar_off = bus.araddr - BASE;
  assign aw_off = bus.awaddr - BASE;
  assign ar_in  = (ar_off < SPAN);
  assign aw_in  = (aw_off < SPAN);
  assign ar_idx = ar_off[AW+1:2];
  assign aw_idx = aw_off[AW+1:2];

  // Readies exist only in IDLE and are forced low while reset is held.
  // A read beats a write offered in the same cycle; AW and W are taken
  // together or not at all.
  logic idle;
  logic rd_accept;
  logic wr_accept;

  assign idle      = rst && (state == ST_IDLE);
  assign rd_accept = idle && bus.arvalid;
  assign wr_accept = idle && bus.awvalid && bus.wvalid && !bus.arvalid;

  assign bus.arready = rd_accept;
  assign bus.awready = wr_accept;
  assign bus.wready  = wr_accept;
  assign bus.rvalid  = rvalid_q;
  assign bus.rdata   = rdata_q;
  assign bus.rresp   = rresp_q;
  assign bus.bvalid  = bvalid_q;
  assign bus.bresp   = bresp_q;
  assign dbg_state   = state;

  logic       cnt_load;
  logic [3:0] cnt_load_val;
  logic       cnt_en;
  logic       cnt_done;

  assign cnt_load     = rd_accept || wr_accept;
  assign cnt_load_val = rd_accept ? RD_PRE : WR_PRE;
  assign cnt_en       = (state == ST_RD_WAIT) || (state == ST_WR_WAIT);

  ysyx_24080014_delay_cnt u_delay_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .en       (cnt_en),
    .done     (cnt_done)
  );

  // Array write happens on the accept edge; out-of-range writes are dropped.
  always_ff @(posedge clk) begin
    if (wr_accept && aw_in) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.wstrb[i]) begin
          mem[aw_idx][8*i +: 8] <= bus.wdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      rvalid_q <= 1'b0;
      bvalid_q <= 1'b0;
      rdata_q  <= 32'h0;
      rresp_q  <= RESP_OKAY;
      bresp_q  <= RESP_OKAY;
      rd_idx_q <= '0;
      rd_err_q <= 1'b0;
      wr_err_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (rd_accept) begin
            rd_idx_q <= ar_idx;
            rd_err_q <= !ar_in;
            if (RD_LAT == 1) begin
              state    <= ST_RD_RESP;
              rvalid_q <= 1'b1;
              rdata_q  <= ar_in ? mem[ar_idx] : 32'h0;
              rresp_q  <= ar_in ? RESP_OKAY : RESP_SLVERR;
            end else begin
              state <= ST_RD_WAIT;
            end
          end else if (wr_accept) begin
            wr_err_q <= !aw_in;
            if (WR_LAT == 1) begin
              state    <= ST_WR_RESP;
              bvalid_q <= 1'b1;
              bresp_q  <= aw_in ? RESP_OKAY : RESP_SLVERR;
            end else begin
              state <= ST_WR_WAIT;
            end
          end
        end
        ST_RD_WAIT: begin
          if (cnt_done) begin
            state    <= ST_RD_RESP;
            rvalid_q <= 1'b1;
            rdata_q  <= rd_err_q ? 32'h0 : mem[rd_idx_q];
            rresp_q  <= rd_err_q ? RESP_SLVERR : RESP_OKAY;
          end
        end
        ST_RD_RESP: begin
          if (bus.rready) begin
            state    <= ST_IDLE;
            rvalid_q <= 1'b0;
          end
        end
        ST_WR_WAIT: begin
          if (cnt_done) begin
            state    <= ST_WR_RESP;
            bvalid_q <= 1'b1;
            bresp_q  <= wr_err_q ? RESP_SLVERR : RESP_OKAY;
          end
        end
        ST_WR_RESP: begin
          if (bus.bready) begin
            state    <= ST_IDLE;
            bvalid_q <= 1'b0;
          end
        end
        default: begin
          state    <= ST_IDLE;
          rvalid_q <= 1'b0;
          bvalid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_24080014_sram_resp.sv
module tb_ysyx_24080014_sram_resp;
  import ysyx_24080014_axi_pkg::*;

  localparam logic [31:0] BASE   = 32'h8000_0000;
  localparam int          DEPTH  = 256;
  localparam int          RD_LAT = 3;
  localparam int          WR_LAT = 2;
  localparam int          TMO    = 60;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ysyx_24080014_sram_resp_if bus ();
  sram_state_e dbg_state;

  ysyx_24080014_sram_resp #(
    .BASE   (BASE),
    .DEPTH  (DEPTH),
    .RD_LAT (RD_LAT),
    .WR_LAT (WR_LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- reference model ----------------
  logic [31:0] model_mem [DEPTH];
  logic [34:0] exp_q [$];   // {is_write, resp, data}
  int tests_run    = 0;
  int tests_failed = 0;

  function automatic bit in_range(input logic [31:0] addr);
    longint a = longint'(addr);
    return (a >= longint'(BASE)) && (a < longint'(BASE) + 4 * DEPTH);
  endfunction

  function automatic int idx_of(input logic [31:0] addr);
    return int'((longint'(addr) - longint'(BASE)) / 4);
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    tests_run++;
    if (got !== want) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst) begin
      if (bus.rvalid && bus.rready) begin
        if (exp_q.size() == 0) begin
          chk("r_unexpected", 64'(bus.rdata), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          logic [34:0] e;
          e = exp_q.pop_front();
          chk("r_kind", 64'(1'b0), 64'(e[34]));
          chk("r_resp", 64'(bus.rresp), 64'(e[33:32]));
          chk("r_data", 64'(bus.rdata), 64'(e[31:0]));
        end
      end
      if (bus.bvalid && bus.bready) begin
        if (exp_q.size() == 0) begin
          chk("b_unexpected", 64'(bus.bresp), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          logic [34:0] e;
          e = exp_q.pop_front();
          chk("b_kind", 64'(1'b1), 64'(e[34]));
          chk("b_resp", 64'(bus.bresp), 64'(e[33:32]));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_read(input logic [31:0] addr);
    if (in_range(addr)) exp_q.push_back({1'b0, RESP_OKAY, model_mem[idx_of(addr)]});
    else                exp_q.push_back({1'b0, RESP_SLVERR, 32'h0});
  endtask

  task automatic push_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb);
    if (in_range(addr)) begin
      for (int i = 0; i < 4; i++)
        if (strb[i]) model_mem[idx_of(addr)][8*i +: 8] = data[8*i +: 8];
      exp_q.push_back({1'b1, RESP_OKAY, 32'h0});
    end else begin
      exp_q.push_back({1'b1, RESP_SLVERR, 32'h0});
    end
  endtask

  task automatic do_read(input logic [31:0] addr, input int stall, output logic [31:0] data);
    int n;
    int lat;
    logic [31:0] hold;
    data = 32'h0;
    push_read(addr);
    @(posedge clk); #1;
    bus.araddr = addr; bus.arvalid = 1'b1; bus.rready = (stall == 0);
    for (n = 0; n < TMO; n++) begin
      @(negedge clk);
      if (bus.arready) break;
    end
    if (n == TMO) begin
      chk("ar_timeout", 64'(n), 64'(0));
      bus.arvalid = 1'b0; bus.rready = 1'b0;
      return;
    end
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
    lat = 1;
    for (n = 0; n < TMO; n++) begin
      @(negedge clk);
      if (bus.rvalid) break;
      lat++;
    end
    chk("rd_latency", 64'(lat), 64'(RD_LAT));
    data = bus.rdata;
    hold = bus.rdata;
    if (stall > 0) begin
      for (int s = 0; s < stall; s++) begin
        @(posedge clk); #1;
        bus.arvalid = 1'b1; bus.araddr = addr;
        @(negedge clk);
        chk("r_stall_hold", {31'h0, bus.rvalid, bus.arready, hold},
                            {31'h0, 1'b1, 1'b0, hold});
      end
      @(posedge clk); #1;
      bus.arvalid = 1'b0; bus.rready = 1'b1;
      @(negedge clk);
      data = bus.rdata;
    end
    @(posedge clk); #1;
    bus.rready = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int stall);
    int n;
    int lat;
    push_write(addr, data, strb);
    @(posedge clk); #1;
    bus.awaddr = addr; bus.wdata = data; bus.wstrb = strb;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = (stall == 0);
    for (n = 0; n < TMO; n++) begin
      @(negedge clk);
      if (bus.awready && bus.wready) break;
    end
    if (n == TMO) begin
      chk("aw_timeout", 64'(n), 64'(0));
      bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b0;
      return;
    end
    @(posedge clk); #1;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    lat = 1;
    for (n = 0; n < TMO; n++) begin
      @(negedge clk);
      if (bus.bvalid) break;
      lat++;
    end
    chk("wr_latency", 64'(lat), 64'(WR_LAT));
    if (stall > 0) begin
      for (int s = 0; s < stall; s++) begin
        @(posedge clk); #1;
        @(negedge clk);
        chk("b_stall_hold", 64'(bus.bvalid), 64'(1));
      end
      @(posedge clk); #1;
      bus.bready = 1'b1;
      @(negedge clk);
    end
    @(posedge clk); #1;
    bus.bready = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] d;
    logic [31:0] a;
    logic [31:0] sum_dut;
    logic [31:0] sum_ref;
    int bad;
    int n;
    logic [31:0] oob_list [4];
    oob_list[0] = BASE - 32'd4;
    oob_list[1] = BASE + 32'(4 * DEPTH);
    oob_list[2] = 32'h0;
    oob_list[3] = 32'hFFFF_FFFC;

    bus.araddr = '0; bus.arvalid = 1'b1; bus.rready = 1'b0;
    bus.awaddr = '0; bus.awvalid = 1'b1; bus.wdata = '0; bus.wstrb = '0;
    bus.wvalid = 1'b1; bus.bready = 1'b0;

    // reset values, with every request valid held high
    #3;
    chk("rst_readies", {61'h0, bus.arready, bus.awready, bus.wready}, 64'h0);
    chk("rst_valids", {62'h0, bus.rvalid, bus.bvalid}, 64'h0);
    chk("rst_data", {28'h0, bus.rresp, bus.bresp, bus.rdata}, 64'h0);
    chk("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    bus.arvalid = 1'b0; bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    #20 rst = 1'b1;

    // fill the whole array so the model is fully defined
    for (int i = 0; i < DEPTH; i++)
      do_write(BASE + 32'(4 * i), $urandom, 4'hF, 0);

    // 1: preloaded word, RD_LAT latency with rready held high
    do_write(BASE, 32'hDEAD_BEEF, 4'hF, 0);
    do_read(BASE, 0, d);
    chk("t1_data", 64'(d), 64'(32'hDEAD_BEEF));

    // 2: partial strobe merge
    do_write(BASE + 32'd4, 32'hAAAA_AAAA, 4'hF, 0);
    do_write(BASE + 32'd4, 32'h1122_3344, 4'b0101, 0);
    do_read(BASE + 32'd4, 0, d);
    chk("t2_merge", 64'(d), 64'(32'hAA22_AA44));

    // 3: out-of-range read/write, array checksum untouched
    do_read(BASE - 32'd4, 0, d);
    do_write(BASE + 32'(4 * DEPTH), 32'h5A5A_5A5A, 4'hF, 0);
    sum_dut = 32'h0;
    sum_ref = 32'h0;
    for (int i = 0; i < DEPTH; i++) begin
      sum_ref = sum_ref + model_mem[i];
      do_read(BASE + 32'(4 * i), 0, d);
      sum_dut = sum_dut + d;
    end
    chk("t3_checksum", 64'(sum_dut), 64'(sum_ref));

    // 4: read and write offered together; read first, one idle cycle, write
    a = BASE + 32'd8;
    push_read(a);
    push_write(BASE + 32'd12, 32'hCAFE_F00D, 4'hF);
    @(posedge clk); #1;
    bus.araddr = a; bus.arvalid = 1'b1;
    bus.awaddr = BASE + 32'd12; bus.wdata = 32'hCAFE_F00D; bus.wstrb = 4'hF;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.rready = 1'b1; bus.bready = 1'b1;
    @(negedge clk);
    chk("t4_arb", {61'h0, bus.arready, bus.awready, bus.wready}, 64'b100);
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
    bad = 0;
    for (n = 0; n < TMO; n++) begin
      @(negedge clk);
      if (bus.awready || bus.wready) bad++;
      if (bus.rvalid) break;
    end
    chk("t4_aw_held_off", 64'(bad), 64'(0));
    @(posedge clk); #1;
    @(negedge clk);
    chk("t4_bubble_accept", {62'h0, bus.awready, bus.rvalid}, 64'b10);
    @(posedge clk); #1;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    for (n = 0; n < TMO; n++) begin
      @(negedge clk);
      if (bus.bvalid) break;
    end
    chk("t4_bvalid_seen", 64'(bus.bvalid), 64'(1));
    @(posedge clk); #1;
    bus.rready = 1'b0; bus.bready = 1'b0;

    // 5: response stall with a competing read request
    do_read(BASE + 32'd16, 5, d);

    // 6: reset during RD_WAIT drops the read
    @(posedge clk); #1;
    bus.araddr = BASE; bus.arvalid = 1'b1;
    @(negedge clk);
    chk("t6_accept", 64'(bus.arready), 64'(1));
    @(posedge clk); #1;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    #2 rst = 1'b0;
    #1;
    chk("t6_rst_readies", {61'h0, bus.arready, bus.awready, bus.wready}, 64'h0);
    chk("t6_rst_outs", {26'h0, bus.rvalid, bus.bvalid, bus.rresp, bus.bresp, bus.rdata}, 64'h0);
    bus.arvalid = 1'b0; bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.rready = 1'b1;
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.rvalid || bus.bvalid) bad++;
    end
    chk("t6_no_resp", 64'(bad), 64'(0));
    bus.rready = 1'b0;
    do_read(BASE, 0, d);
    do_read(BASE + 32'd4, 0, d);

    // randomized mix against the model
    for (int k = 0; k < 200; k++) begin
      if ($urandom_range(0, 9) == 0) a = oob_list[$urandom_range(0, 3)];
      else a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 0)
        do_read(a, $urandom_range(0, 2), d);
      else
        do_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 2));
    end

    repeat (4) @(posedge clk);
    chk("sb_drained", 64'(exp_q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, %0d expected responses pending", exp_q.size());
    $fatal(1, "watchdog expired");
  end

endmodule
